// File: rtl/median_filter_ctrl_pkg.sv
// median_filter_ctrl_pkg: default pixel/address widths and the filter FSM state encoding
package median_filter_ctrl_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  typedef enum logic [3:0] {IDLE, ADDR, RD, CAP, MED1, MED2, MED3, WADDR, WR, NEXT, DONE} state_t;
endpackage

// File: rtl/median_filter_ctrl_if.sv
// median_filter_ctrl_if: start/busy/done, window read (addr_*_r, rd, win_p1..p9) and filtered write (addr_*_w, cl_pixel, wr); master = filter, slave = memory/host
interface median_filter_ctrl_if #(
  parameter int DATA_W = median_filter_ctrl_pkg::DATA_W_DEF,
  parameter int ADDR_W = median_filter_ctrl_pkg::ADDR_W_DEF
);
  logic start, busy, done, rd, wr;
  logic [ADDR_W-1:0] addr_row_r, addr_col_r, addr_row_w, addr_col_w;
  logic [DATA_W-1:0] win_p1, win_p2, win_p3, win_p4, win_p5, win_p6, win_p7, win_p8, win_p9;
  logic [DATA_W-1:0] cl_pixel;
  modport master (
    input  start, win_p1, win_p2, win_p3, win_p4, win_p5, win_p6, win_p7, win_p8, win_p9,
    output busy, done, rd, wr, addr_row_r, addr_col_r, addr_row_w, addr_col_w, cl_pixel
  );
  modport slave (
    output start, win_p1, win_p2, win_p3, win_p4, win_p5, win_p6, win_p7, win_p8, win_p9,
    input  busy, done, rd, wr, addr_row_r, addr_col_r, addr_row_w, addr_col_w, cl_pixel
  );
endinterface

// File: rtl/median_filter_ctrl_core.sv
// median3x3_core: three-stage 3x3 median sort network advancing on en; clk, rst (sync, active-low), en, win (p1..p9, p1 at index 0) in, med out
module median3x3_core
  import median_filter_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [8:0][DATA_W-1:0] win,
  output logic [DATA_W-1:0]      med
);
  typedef logic [DATA_W-1:0] px_t;
  logic [2:0][2:0][DATA_W-1:0] row;
  px_t mx_lo, md_mid, mn_hi;
  function automatic px_t mn(input px_t a, input px_t b);
    return a < b ? a : b;
  endfunction
  function automatic px_t mx(input px_t a, input px_t b);
    return a < b ? b : a;
  endfunction
  function automatic px_t md(input px_t a, input px_t b, input px_t c);
    return mx(mn(a, b), mn(mx(a, b), c));
  endfunction
  always_ff @(posedge clk)
    if (!rst) begin
      row    <= '0;
      mx_lo  <= '0;
      md_mid <= '0;
      mn_hi  <= '0;
      med    <= '0;
    end else if (en) begin
      for (int i = 0; i < 3; i++) begin
        row[i][0] <= mn(mn(win[3*i], win[3*i+1]), win[3*i+2]);
        row[i][1] <= md(win[3*i], win[3*i+1], win[3*i+2]);
        row[i][2] <= mx(mx(win[3*i], win[3*i+1]), win[3*i+2]);
      end
      mx_lo  <= mx(mx(row[0][0], row[1][0]), row[2][0]);
      md_mid <= md(row[0][1], row[1][1], row[2][1]);
      mn_hi  <= mn(mn(row[0][2], row[1][2]), row[2][2]);
      med    <= md(mx_lo, md_mid, mn_hi);
    end
endmodule

// File: rtl/median_filter_ctrl.sv
// median_filter_ctrl: raster 3x3 median pass over image memory; clk, rst (sync, active-low), bus (start/busy/done, window read, filtered write)
module median_filter_ctrl
  import median_filter_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int IMG_SIZE = 256
) (
  input logic                  clk,
  input logic                  rst,
  median_filter_ctrl_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_SIZE - 3);
  state_t state;
  logic [ADDR_W-1:0] r, c, nr, nc;
  logic [8:0][DATA_W-1:0] win;
  logic [DATA_W-1:0] med;
  logic en, last;
  assign last = r == LAST && c == LAST;
  assign nc   = c == LAST ? '0 : c + 1'b1;
  assign nr   = c == LAST ? r + 1'b1 : r;
  assign en   = state inside {MED1, MED2, MED3};
  assign bus.cl_pixel = med;
  median3x3_core #(.DATA_W(DATA_W)) u_core (
    .clk(clk),
    .rst(rst),
    .en (en),
    .win(win),
    .med(med)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state          <= IDLE;
      r              <= '0;
      c              <= '0;
      win            <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.rd         <= 1'b0;
      bus.wr         <= 1'b0;
      bus.addr_row_r <= '0;
      bus.addr_col_r <= '0;
      bus.addr_row_w <= '0;
      bus.addr_col_w <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.rd   <= 1'b0;
      bus.wr   <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state          <= ADDR;
          r              <= '0;
          c              <= '0;
          bus.busy       <= 1'b1;
          bus.addr_row_r <= '0;
          bus.addr_col_r <= '0;
        end
        ADDR: begin
          state  <= RD;
          bus.rd <= 1'b1;
        end
        RD:   state <= CAP;
        CAP: begin
          state <= MED1;
          win   <= {bus.win_p9, bus.win_p8, bus.win_p7, bus.win_p6, bus.win_p5,
                    bus.win_p4, bus.win_p3, bus.win_p2, bus.win_p1};
        end
        MED1: state <= MED2;
        MED2: state <= MED3;
        MED3: begin
          state          <= WADDR;
          bus.addr_row_w <= r + 1'b1;
          bus.addr_col_w <= c + 1'b1;
        end
        WADDR: begin
          state  <= WR;
          bus.wr <= 1'b1;
        end
        WR:   state <= NEXT;
        NEXT: if (last) begin
          state    <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end else begin
          state          <= ADDR;
          r              <= nr;
          c              <= nc;
          bus.addr_row_r <= nr;
          bus.addr_col_r <= nc;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_median_filter_ctrl.sv
// tb_median_filter_ctrl: scoreboard bench for median_filter_ctrl on a 5x5 image
module tb_median_filter_ctrl;
  localparam int IMG = 5;
  localparam int NW  = IMG - 2;
  typedef struct {int r; int c; int p;} exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] img [IMG][IMG];
  logic [7:0] ra = '0, ca = '0;
  exp_t rq[$], wq[$];
  int vec = 0, miss = 0;
  median_filter_ctrl_if #(.DATA_W(8), .ADDR_W(8)) bus ();
  median_filter_ctrl #(.DATA_W(8), .ADDR_W(8), .IMG_SIZE(IMG)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.rd) begin
    ra <= bus.addr_row_r;
    ca <= bus.addr_col_r;
  end
  assign bus.win_p1 = img[ra][ca];
  assign bus.win_p2 = img[ra][ca+1];
  assign bus.win_p3 = img[ra][ca+2];
  assign bus.win_p4 = img[ra+1][ca];
  assign bus.win_p5 = img[ra+1][ca+1];
  assign bus.win_p6 = img[ra+1][ca+2];
  assign bus.win_p7 = img[ra+2][ca];
  assign bus.win_p8 = img[ra+2][ca+1];
  assign bus.win_p9 = img[ra+2][ca+2];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int med9(input int r, input int c);
    int v[9];
    int t;
    for (int i = 0; i < 9; i++) v[i] = int'(img[r + i / 3][c + i % 3]);
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j];
          v[j] = v[j+1];
          v[j+1] = t;
        end
    return v[4];
  endfunction
  task automatic push(input int nrd, input int nwr);
    for (int k = 0; k < nrd; k++) rq.push_back('{k / NW, k % NW, 0});
    for (int k = 0; k < nwr; k++) wq.push_back('{k / NW + 1, k % NW + 1, med9(k / NW, k % NW)});
  endtask
  task automatic fill(input int v);
    for (int i = 0; i < IMG; i++)
      for (int j = 0; j < IMG; j++)
        img[i][j] = v < 0 ? 8'($urandom_range(0, 255)) : 8'(v);
  endtask
  task automatic check_idle(input string t);
    chk({t, "_busy"}, bus.busy, 0);
    chk({t, "_done"}, bus.done, 0);
    chk({t, "_rd"}, bus.rd, 0);
    chk({t, "_wr"}, bus.wr, 0);
    chk({t, "_addr_row_r"}, bus.addr_row_r, 0);
    chk({t, "_addr_col_r"}, bus.addr_col_r, 0);
    chk({t, "_addr_row_w"}, bus.addr_row_w, 0);
    chk({t, "_addr_col_w"}, bus.addr_col_w, 0);
    chk({t, "_cl_pixel"}, bus.cl_pixel, 0);
  endtask
  task automatic run_pass(input string t);
    int n, fw;
    fw = -1;
    push(NW * NW, NW * NW);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 200) begin
      bus.start = n == 20 || n == 47;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n++;
      if (bus.wr && fw < 0) fw = n;
      if (n == 40) chk({t, "_busy_mid"}, bus.busy, 1);
    end
    chk({t, "_first_wr_edge"}, fw, 7);
    chk({t, "_done_edge"}, n, NW * NW * 9);
    chk({t, "_busy_at_done"}, bus.busy, 0);
    chk({t, "_reads_left"}, rq.size(), 0);
    chk({t, "_writes_left"}, wq.size(), 0);
    @(posedge clk); #1;
    chk({t, "_done_pulse"}, bus.done, 0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    chk("rd_wr_overlap", bus.rd & bus.wr, 0);
    if (bus.rd) begin
      if (rq.size() == 0) chk("rd_unexpected", bus.rd, 0);
      else begin
        e = rq.pop_front();
        chk("rd_row", bus.addr_row_r, e.r);
        chk("rd_col", bus.addr_col_r, e.c);
      end
    end
    if (bus.wr) begin
      if (wq.size() == 0) chk("wr_unexpected", bus.wr, 0);
      else begin
        e = wq.pop_front();
        chk("wr_row", bus.addr_row_w, e.r);
        chk("wr_col", bus.addr_col_w, e.c);
        chk("wr_pixel", bus.cl_pixel, e.p);
      end
    end
  end
  initial begin
    int perm [9];
    perm = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    rst = 1'b0;
    bus.start = 1'b1;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("post_reset");
    fill(50);
    run_pass("const50");
    fill(-1);
    for (int i = 0; i < 9; i++) img[i / 3][i % 3] = 8'(perm[i]);
    run_pass("permuted");
    fill(10);
    img[1][1] = 8'd255;
    run_pass("impulse");
    fill(255);
    img[0][0] = 8'd0;
    img[0][2] = 8'd0;
    img[2][0] = 8'd0;
    img[2][2] = 8'd0;
    run_pass("zeros255");
    fill(-1);
    run_pass("random");
    fill(-1);
    push(4, 3);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle("abort");
    rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_reads_left", rq.size(), 0);
    chk("abort_writes_left", wq.size(), 0);
    run_pass("restart");
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
